// File: rtl/seq_hit_pkg.sv
// ---------------------------------------------------------------------------
// seq_hit_pkg
// Shared defaults for the sequence-hit timestamp logger.
//   TS_W_DEFAULT  : timestamp counter / FIFO entry width
//   DEPTH_DEFAULT : FIFO depth (power of two, >= 2)
//   CNT_W_DEFAULT : saturating hit counter width
// ---------------------------------------------------------------------------
package seq_hit_pkg;

    localparam int unsigned TS_W_DEFAULT  = 16;
    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/hit_fifo.sv
// ---------------------------------------------------------------------------
// hit_fifo
// Small synchronous FIFO holding captured timestamps.
//   clk, rst      : clock, asynchronous active-low reset (pointers only)
//   i_clr         : synchronous clear, wins over push/pop
//   i_push/i_din  : write request and data
//   i_pop         : read request; ignored while empty
//   o_dout        : head entry, read from registered storage
//   o_valid       : FIFO non-empty
//   o_full        : FIFO holds DEPTH entries
// A push while full is accepted only if a pop retires the head on the same
// edge; otherwise it is dropped and storage is left untouched.
// ---------------------------------------------------------------------------
module hit_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is deliberately not reset; stale entries are hidden by o_valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_valid = ~w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/seq_hit_logger.sv
// ---------------------------------------------------------------------------
// seq_hit_logger
// Timestamps detection pulses from an upstream sequence detector and queues
// them for a consumer.
//   clk, rst   : clock, asynchronous active-low reset
//   hit_in     : one-cycle detection pulse
//   en         : gates timestamp counting, capture and hit counting
//   clr        : synchronous clear of queue, timestamp, counter, overflow
//   ts_data    : timestamp at the queue head (valid when ts_valid)
//   ts_valid   : queue non-empty
//   ts_ready   : consumer takes the head entry
//   hit_count  : saturating count of all enabled hits, accepted or dropped
//   overflow   : sticky, a hit was dropped on a full queue
//   full       : queue holds DEPTH entries
// ---------------------------------------------------------------------------
module seq_hit_logger
    import seq_hit_pkg::*;
#(
    parameter int unsigned TS_W  = TS_W_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit_in,
    input  logic             en,
    input  logic             clr,
    output logic [TS_W-1:0]  ts_data,
    output logic             ts_valid,
    input  logic             ts_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic             overflow,
    output logic             full
);

    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [TS_W-1:0]  r_ts_cnt;
    logic [CNT_W-1:0] r_hit_count;
    logic             r_overflow;

    logic w_push_req;
    logic w_full;
    logic w_drop;
    logic w_cnt_sat;

    assign w_push_req = hit_in & en;
    // Full implies valid, so ts_ready alone means the head retires this edge.
    assign w_drop     = w_push_req & w_full & ~ts_ready;
    assign w_cnt_sat  = &r_hit_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts_cnt    <= '0;
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else if (clr) begin
            r_ts_cnt    <= '0;
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (en) begin
                r_ts_cnt <= r_ts_cnt + TS_ONE;
            end
            if (w_push_req && !w_cnt_sat) begin
                r_hit_count <= r_hit_count + CNT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // The pre-increment counter value is what gets stored.
    hit_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clr),
        .i_push  (w_push_req),
        .i_din   (r_ts_cnt),
        .i_pop   (ts_ready),
        .o_dout  (ts_data),
        .o_valid (ts_valid),
        .o_full  (w_full)
    );

    assign hit_count = r_hit_count;
    assign overflow  = r_overflow;
    assign full      = w_full;

endmodule

// File: tb/tb_seq_hit_logger.sv
module tb_seq_hit_logger;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hit_in = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic ts_ready = 1'b0;

    // Instance A: default widths. Instance B: TS_W=4, CNT_W=3. Same stimulus.
    logic [15:0] ts_data_a;
    logic        ts_valid_a;
    logic [7:0]  hit_count_a;
    logic        overflow_a;
    logic        full_a;
    logic [3:0]  ts_data_b;
    logic        ts_valid_b;
    logic [2:0]  hit_count_b;
    logic        overflow_b;
    logic        full_b;

    always #5 clk = ~clk;

    seq_hit_logger u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .hit_in    (hit_in),
        .en        (en),
        .clr       (clr),
        .ts_data   (ts_data_a),
        .ts_valid  (ts_valid_a),
        .ts_ready  (ts_ready),
        .hit_count (hit_count_a),
        .overflow  (overflow_a),
        .full      (full_a)
    );

    seq_hit_logger #(
        .TS_W  (4),
        .DEPTH (4),
        .CNT_W (3)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .hit_in    (hit_in),
        .en        (en),
        .clr       (clr),
        .ts_data   (ts_data_b),
        .ts_valid  (ts_valid_b),
        .ts_ready  (ts_ready),
        .hit_count (hit_count_b),
        .overflow  (overflow_b),
        .full      (full_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an unbounded queue of timestamps, a free-running
    // enabled-edge count and a plain hit total; widths applied when compared.
    int m_q[$];
    int m_ts   = 0;
    int m_hits = 0;
    bit m_ovf  = 1'b0;

    function automatic void model_reset();
        m_q.delete();
        m_ts   = 0;
        m_hits = 0;
        m_ovf  = 1'b0;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock edge: model sees the pre-edge inputs, outputs sampled #1 after.
    task automatic tick();
        bit p_pop;
        bit p_push;
        int p_size;
        p_size = m_q.size();
        p_pop  = ts_ready && (p_size != 0);
        p_push = hit_in && en;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            if (p_pop) void'(m_q.pop_front());
            if (p_push) begin
                m_hits++;
                if (p_size < DEPTH || p_pop) m_q.push_back(m_ts);
                else m_ovf = 1'b1;
            end
            if (en) m_ts = (m_ts + 1) & 16'hFFFF;
        end
        #1;
    endtask

    task automatic apply_reset();
        hit_in   = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        ts_ready = 1'b0;
        rst      = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Power-on reset, checked before any clock edge.
        #1 rst = 1'b0;
        #2;
        n_checks++;
        if ({ts_valid_a, overflow_a, full_a, hit_count_a} !== 11'd0) begin
            n_errors++;
            $display("FAIL por_a: got v=%0b o=%0b f=%0b cnt=%0d required all 0",
                     ts_valid_a, overflow_a, full_a, hit_count_a);
        end
        #5 rst = 1'b1;
        @(posedge clk);
        #1;
        // Two entries queued, then asynchronous reset mid-stream.
        en = 1'b1;
        hit_in = 1'b1;
        tick();
        tick();
        hit_in = 1'b0;
        tick();
        n_checks++;
        if (full_a !== 1'b0 || ts_valid_a !== 1'b1 || hit_count_a !== 8'd2) begin
            n_errors++;
            $display("FAIL prefill: got v=%0b cnt=%0d required v=1 cnt=2",
                     ts_valid_a, hit_count_a);
        end
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({ts_valid_a, overflow_a, full_a, hit_count_a} !== 11'd0 ||
            {ts_valid_b, overflow_b, full_b, hit_count_b} !== 6'd0) begin
            n_errors++;
            $display("FAIL async_rst: got v=%0b o=%0b f=%0b cnt=%0d required all 0",
                     ts_valid_a, overflow_a, full_a, hit_count_a);
        end
        #1 rst = 1'b1;
        hit_in = 1'b1;
        tick();
        hit_in = 1'b0;
        en = 1'b0;
        n_checks++;
        if (ts_valid_a !== 1'b1 || ts_data_a !== 16'd0) begin
            n_errors++;
            $display("FAIL first_edge_ts: got v=%0b data=%0d required v=1 data=0",
                     ts_valid_a, ts_data_a);
        end
    endtask

    task automatic test_single_hit();
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        hit_in = 1'b1;
        tick();
        hit_in = 1'b0;
        n_checks++;
        if (ts_valid_a !== 1'b1 || ts_data_a !== 16'd5 || hit_count_a !== 8'd1) begin
            n_errors++;
            $display("FAIL single_hit: got v=%0b data=%0d cnt=%0d required v=1 data=5 cnt=1",
                     ts_valid_a, ts_data_a, hit_count_a);
        end
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
        n_checks++;
        if (ts_valid_a !== 1'b0) begin
            n_errors++;
            $display("FAIL single_pop: got v=%0b required v=0", ts_valid_a);
        end
    endtask

    task automatic test_overflow();
        int exp_drain[4] = '{1, 2, 3, 4};
        apply_reset();
        en = 1'b1;
        tick();                          // ts 0, no hit
        hit_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();   // hits at ts 1..4
        hit_in = 1'b0;
        n_checks++;
        if (full_a !== 1'b1 || overflow_a !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_full4: got full=%0b ovf=%0b required full=1 ovf=0",
                     full_a, overflow_a);
        end
        tick();                          // ts 5
        hit_in = 1'b1;
        tick();                          // ts 6, dropped
        hit_in = 1'b0;
        en = 1'b0;
        n_checks++;
        if (overflow_a !== 1'b1 || hit_count_a !== 8'd5 || full_a !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_set: got ovf=%0b cnt=%0d full=%0b required ovf=1 cnt=5 full=1",
                     overflow_a, hit_count_a, full_a);
        end
        ts_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ts_valid_a !== 1'b1 || ts_data_a !== 16'(exp_drain[i])) begin
                n_errors++;
                $display("FAIL ovf_drain[%0d]: got v=%0b data=%0d required v=1 data=%0d",
                         i, ts_valid_a, ts_data_a, exp_drain[i]);
            end
            tick();
        end
        ts_ready = 1'b0;
        n_checks++;
        if (ts_valid_a !== 1'b0 || overflow_a !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky: got v=%0b ovf=%0b required v=0 ovf=1",
                     ts_valid_a, overflow_a);
        end
        // Asynchronous reset clears the sticky flag and the count.
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (overflow_a !== 1'b0 || hit_count_a !== 8'd0) begin
            n_errors++;
            $display("FAIL ovf_rst: got ovf=%0b cnt=%0d required 0 0", overflow_a, hit_count_a);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_push_pop();
        int exp_drain[4] = '{2, 3, 4, 9};
        apply_reset();
        en = 1'b1;
        tick();
        hit_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        hit_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();   // ts 5..8
        hit_in = 1'b1;
        ts_ready = 1'b1;
        tick();                          // ts 9: push and pop while full
        hit_in = 1'b0;
        ts_ready = 1'b0;
        en = 1'b0;
        n_checks++;
        if (overflow_a !== 1'b0 || full_a !== 1'b1) begin
            n_errors++;
            $display("FAIL full_pp: got ovf=%0b full=%0b required ovf=0 full=1",
                     overflow_a, full_a);
        end
        ts_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ts_valid_a !== 1'b1 || ts_data_a !== 16'(exp_drain[i])) begin
                n_errors++;
                $display("FAIL full_pp_drain[%0d]: got v=%0b data=%0d required v=1 data=%0d",
                         i, ts_valid_a, ts_data_a, exp_drain[i]);
            end
            tick();
        end
        ts_ready = 1'b0;
    endtask

    task automatic test_wrap_sat();
        apply_reset();
        en = 1'b1;
        ts_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            hit_in = (i % 3 == 0);
            tick();
            if (i % 3 == 0) begin
                n_checks++;
                if (ts_valid_b !== 1'b1 || ts_data_b !== 4'(i % 16)) begin
                    n_errors++;
                    $display("FAIL wrap[%0d]: got v=%0b data=%0d required v=1 data=%0d",
                             i / 3, ts_valid_b, ts_data_b, i % 16);
                end
            end
        end
        hit_in = 1'b0;
        n_checks++;
        if (hit_count_b !== 3'd7 || hit_count_a !== 8'd10) begin
            n_errors++;
            $display("FAIL sat: got b=%0d a=%0d required b=7 a=10", hit_count_b, hit_count_a);
        end
        ts_ready = 1'b0;
    endtask

    // Behavioural overlapping Mealy detector for "1101"; y drives hit_in.
    task automatic test_detector();
        logic [10:0] stream = 11'b11011011101;
        logic [2:0]  hist;
        int          exp_q[$];
        logic        y;
        apply_reset();
        en   = 1'b1;
        hist = 3'b000;
        for (int i = 0; i < 11; i++) begin
            y = (hist == 3'b110) && stream[10-i];
            hit_in = y;
            if (y) exp_q.push_back(i);
            tick();
            hist = {hist[1:0], stream[10-i]};
        end
        hit_in = 1'b0;
        en = 1'b0;
        n_checks++;
        if (hit_count_a !== 8'(exp_q.size()) || exp_q.size() != 3) begin
            n_errors++;
            $display("FAIL det_count: got %0d required %0d", hit_count_a, exp_q.size());
        end
        ts_ready = 1'b1;
        foreach (exp_q[k]) begin
            n_checks++;
            if (ts_valid_a !== 1'b1 || ts_data_a !== 16'(exp_q[k])) begin
                n_errors++;
                $display("FAIL det_ts[%0d]: got v=%0b data=%0d required v=1 data=%0d",
                         k, ts_valid_a, ts_data_a, exp_q[k]);
            end
            tick();
        end
        ts_ready = 1'b0;
        n_checks++;
        if (ts_valid_a !== 1'b0) begin
            n_errors++;
            $display("FAIL det_empty: got v=%0b required 0", ts_valid_a);
        end
        // Rerun partially, then clr mid-run together with a hit.
        apply_reset();
        en   = 1'b1;
        hist = 3'b000;
        for (int i = 0; i < 7; i++) begin
            hit_in = (hist == 3'b110) && stream[10-i];
            tick();
            hist = {hist[1:0], stream[10-i]};
        end
        hit_in = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if ({ts_valid_a, overflow_a, full_a, hit_count_a} !== 11'd0) begin
            n_errors++;
            $display("FAIL det_clr: got v=%0b o=%0b f=%0b cnt=%0d required all 0",
                     ts_valid_a, overflow_a, full_a, hit_count_a);
        end
        tick();                          // ts restarted from 0
        hit_in = 1'b0;
        en = 1'b0;
        n_checks++;
        if (ts_valid_a !== 1'b1 || ts_data_a !== 16'd0 || hit_count_a !== 8'd1) begin
            n_errors++;
            $display("FAIL clr_ts0: got v=%0b data=%0d cnt=%0d required v=1 data=0 cnt=1",
                     ts_valid_a, ts_data_a, hit_count_a);
        end
    endtask

    task automatic test_random();
        bit exp_v;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            hit_in   = ($urandom_range(0, 1) == 1);
            ts_ready = ($urandom_range(0, 2) == 0);
            clr      = ($urandom_range(0, 59) == 0);
            tick();
            exp_v = (m_q.size() != 0);
            n_checks++;
            if (ts_valid_a !== exp_v || full_a !== (m_q.size() == DEPTH) ||
                overflow_a !== m_ovf || hit_count_a !== 8'(sat(m_hits, 255))) begin
                n_errors++;
                $display("FAIL rand_a[%0d]: got v=%0b f=%0b o=%0b c=%0d required v=%0b f=%0b o=%0b c=%0d",
                         i, ts_valid_a, full_a, overflow_a, hit_count_a, exp_v,
                         m_q.size() == DEPTH, m_ovf, sat(m_hits, 255));
            end
            n_checks++;
            if (ts_valid_b !== exp_v || full_b !== (m_q.size() == DEPTH) ||
                overflow_b !== m_ovf || hit_count_b !== 3'(sat(m_hits, 7))) begin
                n_errors++;
                $display("FAIL rand_b[%0d]: got v=%0b f=%0b o=%0b c=%0d required v=%0b c=%0d",
                         i, ts_valid_b, full_b, overflow_b, hit_count_b, exp_v,
                         sat(m_hits, 7));
            end
            if (exp_v) begin
                n_checks++;
                if (ts_data_a !== 16'(m_q[0]) || ts_data_b !== 4'(m_q[0] & 15)) begin
                    n_errors++;
                    $display("FAIL rand_data[%0d]: got a=%0d b=%0d required a=%0d b=%0d",
                             i, ts_data_a, ts_data_b, m_q[0], m_q[0] & 15);
                end
            end
        end
        clr = 1'b0;
        hit_in = 1'b0;
        en = 1'b0;
        ts_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_overflow();
        test_full_push_pop();
        test_wrap_sat();
        test_detector();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
